// File: rtl/cv32e40p_obi_data_mem_bridge.sv
// OBI data-port to fixed-latency single-port SRAM bridge.
// Requests inside the mapped window go to the SRAM. Requests outside it are
// granted locally and answered with an error. Every response returns in grant
// order, and the number of granted-but-unanswered transactions is capped.
//
// Handshake semantics:
//   The core raises data_req_i and holds the request fields stable until it
//   sees data_gnt_o high in the same cycle. A request is accepted exactly in
//   that cycle. For each accepted request, data_rvalid_o pulses for one cycle
//   exactly MEM_LATENCY cycles later, and there is no backpressure on
//   responses. mem_req_o/mem_gnt_i follow the same rule: the SRAM accepts in
//   a cycle where both are high.
module cv32e40p_obi_data_mem_bridge #(
  parameter logic [31:0] MEM_BASE        = 32'h0010_0000,
  parameter int unsigned MEM_SIZE_BYTES  = 65536,
  parameter int unsigned MEM_LATENCY     = 1,
  parameter int unsigned MAX_OUTSTANDING = 2,
  localparam int unsigned AW             = $clog2(MEM_SIZE_BYTES / 4)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          data_req_i,
  output logic          data_gnt_o,
  input  logic          data_we_i,
  input  logic [3:0]    data_be_i,
  input  logic [31:0]   data_addr_i,
  input  logic [31:0]   data_wdata_i,
  output logic          data_rvalid_o,
  output logic [31:0]   data_rdata_o,
  output logic          data_err_o,
  output logic          mem_req_o,
  input  logic          mem_gnt_i,
  output logic          mem_we_o,
  output logic [3:0]    mem_be_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [31:0]   mem_wdata_o,
  input  logic [31:0]   mem_rdata_i,
  output logic          busy_o
);

  localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_OUTSTANDING);

  logic [31:0]            offset;
  logic                   in_range;
  logic                   slot_ok;
  logic                   grant;
  logic [CW-1:0]          cnt;
  logic [MEM_LATENCY-1:0] pipe_v;
  logic [MEM_LATENCY-1:0] pipe_err;
  logic [MEM_LATENCY-1:0] pipe_we;
  logic                   rsp_v;
  logic                   rsp_err;
  logic                   rsp_we;

  // The unsigned subtraction makes addresses below the base wrap to large
  // values, so one compare covers both ends of the window.
  assign offset   = data_addr_i - MEM_BASE;
  assign in_range = offset < MEM_SIZE_BYTES;

  // A response retiring this cycle frees its slot for a new grant in the
  // same cycle.
  assign slot_ok    = (cnt < CNT_MAX) || data_rvalid_o;
  assign mem_req_o  = data_req_i & slot_ok & in_range;
  assign data_gnt_o = data_req_i & slot_ok & (in_range ? mem_gnt_i : 1'b1);
  assign grant      = data_gnt_o;

  assign mem_addr_o  = offset[AW+1:2];
  assign mem_we_o    = data_we_i;
  assign mem_be_o    = data_be_i;
  assign mem_wdata_o = data_wdata_i;

  // Response tracking pipeline: one stage per cycle of SRAM latency, so the
  // last stage lines up with the cycle mem_rdata_i is valid.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pipe_v   <= '0;
      pipe_err <= '0;
      pipe_we  <= '0;
    end else begin
      pipe_v[0]   <= grant;
      pipe_err[0] <= grant & ~in_range;
      pipe_we[0]  <= grant & data_we_i;
      for (int i = 1; i < int'(MEM_LATENCY); i++) begin
        pipe_v[i]   <= pipe_v[i-1];
        pipe_err[i] <= pipe_err[i-1];
        pipe_we[i]  <= pipe_we[i-1];
      end
    end
  end

  assign rsp_v   = pipe_v[MEM_LATENCY-1];
  assign rsp_err = pipe_err[MEM_LATENCY-1];
  assign rsp_we  = pipe_we[MEM_LATENCY-1];

  assign data_rvalid_o = rsp_v;
  assign data_err_o    = rsp_v & rsp_err;
  assign data_rdata_o  = (rsp_v & ~rsp_err & ~rsp_we) ? mem_rdata_i : 32'h0;

  // Outstanding counter: a grant and a retirement in the same cycle cancel.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt <= '0;
    end else begin
      case ({grant, data_rvalid_o})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  assign busy_o = cnt != '0;

`ifdef CV32E40P_ASSERT_ON
  a_params: assert property (@(posedge clk_i)
    (MEM_LATENCY >= 1) && (MAX_OUTSTANDING >= 1) && (MEM_SIZE_BYTES >= 8) &&
    ((MEM_SIZE_BYTES & (MEM_SIZE_BYTES - 1)) == 0));
  a_no_rvalid_idle: assert property (@(posedge clk_i) disable iff (!rst_ni)
    data_rvalid_o |-> (cnt != '0));
  a_mem_req_in_range: assert property (@(posedge clk_i) disable iff (!rst_ni)
    mem_req_o |-> in_range);
  a_cnt_bound: assert property (@(posedge clk_i) disable iff (!rst_ni)
    cnt <= CNT_MAX);
`endif

endmodule

// File: tb/tb_cv32e40p_obi_data_mem_bridge.sv
// Bench for the OBI data-port to SRAM bridge. Three instances run side by side:
// (latency 1, 2 outstanding), (latency 3, 3 outstanding) and (latency 4,
// 2 outstanding). Directed scenarios are followed by randomized traffic. A
// transaction-level reference model keeps one queue entry per granted
// transaction, holding the cycle its response is due.
module tb_cv32e40p_obi_data_mem_bridge;

  localparam logic [31:0] BASE = 32'h0010_0000;
  localparam int unsigned SIZE = 65536;
  localparam int N = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        req    [N];
  logic        gnt    [N];
  logic        we     [N];
  logic [3:0]  be     [N];
  logic [31:0] addr   [N];
  logic [31:0] wdata  [N];
  logic        rvalid [N];
  logic [31:0] rdata  [N];
  logic        err    [N];
  logic        mreq   [N];
  logic        mgnt   [N];
  logic        mwe    [N];
  logic [3:0]  mbe    [N];
  logic [13:0] maddr  [N];
  logic [31:0] mwdata [N];
  logic [31:0] mrdata [N];
  logic        busy   [N];

  for (genvar g = 0; g < N; g++) begin : g_dut
    localparam int unsigned L = (g == 0) ? 1 : (g == 1) ? 3 : 4;
    localparam int unsigned M = (g == 0) ? 2 : (g == 1) ? 3 : 2;
    cv32e40p_obi_data_mem_bridge #(
      .MEM_BASE(BASE), .MEM_SIZE_BYTES(SIZE),
      .MEM_LATENCY(L), .MAX_OUTSTANDING(M)
    ) u_dut (
      .clk_i(clk), .rst_ni(rst_n),
      .data_req_i(req[g]), .data_gnt_o(gnt[g]), .data_we_i(we[g]),
      .data_be_i(be[g]), .data_addr_i(addr[g]), .data_wdata_i(wdata[g]),
      .data_rvalid_o(rvalid[g]), .data_rdata_o(rdata[g]), .data_err_o(err[g]),
      .mem_req_o(mreq[g]), .mem_gnt_i(mgnt[g]), .mem_we_o(mwe[g]),
      .mem_be_o(mbe[g]), .mem_addr_o(maddr[g]), .mem_wdata_o(mwdata[g]),
      .mem_rdata_i(mrdata[g]), .busy_o(busy[g])
    );
  end

  function automatic int lat_of(int g);
    return (g == 0) ? 1 : (g == 1) ? 3 : 4;
  endfunction

  function automatic int max_of(int g);
    return (g == 0) ? 2 : (g == 1) ? 3 : 2;
  endfunction

  // ---------------- scoreboard ----------------
  typedef struct {
    int inst;
    int due;
    bit err;
    bit we;
  } rsp_t;

  rsp_t exp_q[$];
  int   cyc;
  int   checks;
  int   failures;
  bit   last_gnt [N];

  task automatic check_val(string tag, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // Called once per cycle, mid-cycle, after the inputs have settled.
  task automatic model_check();
    int          outst;
    int          hit;
    logic [31:0] off;
    bit          inr;
    bit          slot;
    bit          e_gnt;
    bit          e_mreq;
    bit          e_rv;
    bit          e_err;
    logic [31:0] e_rdata;
    rsp_t        r;
    if (!rst_n) exp_q.delete();
    for (int g = 0; g < N; g++) begin
      outst = 0;
      hit   = -1;
      foreach (exp_q[i]) begin
        if (exp_q[i].inst == g) begin
          outst++;
          if (exp_q[i].due == cyc) hit = i;
        end
      end
      off     = addr[g] - BASE;
      inr     = off < SIZE;
      e_rv    = hit >= 0;
      slot    = (outst < max_of(g)) || e_rv;
      e_gnt   = req[g] && slot && (inr ? mgnt[g] : 1'b1);
      e_mreq  = req[g] && slot && inr;
      e_err   = 1'b0;
      e_rdata = 32'h0;
      if (e_rv) begin
        e_err   = exp_q[hit].err;
        e_rdata = (exp_q[hit].err || exp_q[hit].we) ? 32'h0 : mrdata[g];
      end
      check_val($sformatf("i%0d_gnt@%0d", g, cyc), gnt[g], e_gnt);
      check_val($sformatf("i%0d_mreq@%0d", g, cyc), mreq[g], e_mreq);
      check_val($sformatf("i%0d_rvalid@%0d", g, cyc), rvalid[g], e_rv);
      check_val($sformatf("i%0d_err@%0d", g, cyc), err[g], e_err);
      check_val($sformatf("i%0d_rdata@%0d", g, cyc), rdata[g], e_rdata);
      check_val($sformatf("i%0d_busy@%0d", g, cyc), busy[g], outst != 0);
      if (e_mreq) begin
        check_val($sformatf("i%0d_maddr@%0d", g, cyc), maddr[g], (off >> 2) & (SIZE / 4 - 1));
        check_val($sformatf("i%0d_mwe@%0d", g, cyc), mwe[g], we[g]);
        check_val($sformatf("i%0d_mbe@%0d", g, cyc), mbe[g], be[g]);
        check_val($sformatf("i%0d_mwdata@%0d", g, cyc), mwdata[g], wdata[g]);
      end
      if (e_rv) exp_q.delete(hit);
      if (e_gnt && rst_n) begin
        r.inst = g;
        r.due  = cyc + lat_of(g);
        r.err  = !inr;
        r.we   = we[g];
        exp_q.push_back(r);
      end
      last_gnt[g] = e_gnt;
    end
    cyc++;
  endtask

  // ---------------- driver tasks ----------------
  task automatic sample();
    @(negedge clk);
    model_check();
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  task automatic step();
    sample();
    advance();
  endtask

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 9))
      0:       return 32'h0000_0000;
      1:       return BASE - 32'd4;
      2:       return BASE + SIZE;
      3:       return 32'hFFFF_FFFC;
      4:       return BASE + SIZE - 32'd4;
      5:       return BASE;
      default: return BASE + $urandom_range(0, SIZE - 1);
    endcase
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    checks   = 0;
    failures = 0;
    cyc      = 0;
    for (int g = 0; g < N; g++) begin
      req[g] = 1'b0; we[g] = 1'b0; be[g] = 4'h0; addr[g] = 32'h0;
      wdata[g] = 32'h0; mgnt[g] = 1'b1; mrdata[g] = 32'h0; last_gnt[g] = 1'b0;
    end
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Reset values
    sample();
    for (int g = 0; g < N; g++) begin
      check_val($sformatf("rst_rvalid%0d", g), rvalid[g], 1'b0);
      check_val($sformatf("rst_err%0d", g), err[g], 1'b0);
      check_val($sformatf("rst_rdata%0d", g), rdata[g], 32'h0);
      check_val($sformatf("rst_busy%0d", g), busy[g], 1'b0);
    end
    advance();
    rst_n = 1'b1;
    step();

    // Read with default parameters
    req[0] = 1'b1; we[0] = 1'b0; be[0] = 4'hF; addr[0] = 32'h0010_0010;
    mgnt[0] = 1'b1; mrdata[0] = 32'hDEAD_BEEF;
    sample();
    check_val("rd_gnt", gnt[0], 1'b1);
    check_val("rd_mreq", mreq[0], 1'b1);
    check_val("rd_maddr", maddr[0], 32'd4);
    advance();
    req[0] = 1'b0;
    sample();
    check_val("rd_rvalid", rvalid[0], 1'b1);
    check_val("rd_rdata", rdata[0], 32'hDEAD_BEEF);
    check_val("rd_err", err[0], 1'b0);
    advance();

    // Write
    req[0] = 1'b1; we[0] = 1'b1; be[0] = 4'b0011; addr[0] = 32'h0010_0020;
    wdata[0] = 32'h1234_5678;
    sample();
    check_val("wr_gnt", gnt[0], 1'b1);
    check_val("wr_mwe", mwe[0], 1'b1);
    check_val("wr_mbe", mbe[0], 4'b0011);
    check_val("wr_mwdata", mwdata[0], 32'h1234_5678);
    advance();
    req[0] = 1'b0; we[0] = 1'b0;
    sample();
    check_val("wr_rvalid", rvalid[0], 1'b1);
    check_val("wr_rdata", rdata[0], 32'h0);
    advance();

    // Out-of-window reads, granted even while the SRAM refuses
    for (int k = 0; k < 2; k++) begin
      req[0] = 1'b1; we[0] = 1'b0; mgnt[0] = 1'b0;
      addr[0] = (k == 0) ? 32'h0000_0000 : 32'h0011_0000;
      sample();
      check_val($sformatf("oow%0d_mreq", k), mreq[0], 1'b0);
      check_val($sformatf("oow%0d_gnt", k), gnt[0], 1'b1);
      advance();
      req[0] = 1'b0; mgnt[0] = 1'b1;
      sample();
      check_val($sformatf("oow%0d_rvalid", k), rvalid[0], 1'b1);
      check_val($sformatf("oow%0d_err", k), err[0], 1'b1);
      check_val($sformatf("oow%0d_rdata", k), rdata[0], 32'h0);
      advance();
    end

    // SRAM backpressure: no grant and nothing outstanding
    req[0] = 1'b1; addr[0] = 32'h0010_0100; mgnt[0] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      sample();
      check_val($sformatf("bp%0d_gnt", k), gnt[0], 1'b0);
      check_val($sformatf("bp%0d_busy", k), busy[0], 1'b0);
      advance();
    end
    req[0] = 1'b0; mgnt[0] = 1'b1;
    step();

    // Ordering on latency 3: read, bad address, read
    req[1] = 1'b1; we[1] = 1'b0; be[1] = 4'hF; mgnt[1] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      addr[1] = (k == 1) ? 32'h0000_0000 : BASE + 32'h40 * (k + 1);
      sample();
      check_val($sformatf("ord_gnt%0d", k), gnt[1], 1'b1);
      advance();
    end
    req[1] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      mrdata[1] = 32'hA000_0000 + k;
      sample();
      check_val($sformatf("ord_rvalid%0d", k), rvalid[1], 1'b1);
      check_val($sformatf("ord_err%0d", k), err[1], k == 1);
      check_val($sformatf("ord_rdata%0d", k), rdata[1], (k == 1) ? 32'h0 : 32'hA000_0000 + k);
      advance();
    end
    sample();
    check_val("ord_after", rvalid[1], 1'b0);
    advance();

    // Outstanding limit on latency 4, max 2 with request held
    req[2] = 1'b1; we[2] = 1'b0; be[2] = 4'hF; addr[2] = BASE + 32'h80; mgnt[2] = 1'b1;
    for (int k = 0; k < 8; k++) begin
      sample();
      check_val($sformatf("lim_gnt%0d", k), gnt[2], (k % 4) < 2);
      advance();
    end
    req[2] = 1'b0;
    repeat (6) step();

    // Reset with two responses in flight
    req[2] = 1'b1;
    step();
    step();
    req[2] = 1'b0;
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      sample();
      check_val($sformatf("rstf_rvalid%0d", k), rvalid[2], 1'b0);
      check_val($sformatf("rstf_busy%0d", k), busy[2], 1'b0);
      advance();
    end

    // Randomized traffic on all instances, with one reset in the middle
    for (int c = 0; c < 600; c++) begin
      for (int g = 0; g < N; g++) begin
        if (!(req[g] && !last_gnt[g])) begin
          req[g]   = $urandom_range(0, 3) != 0;
          we[g]    = $urandom_range(0, 1) != 0;
          be[g]    = 4'($urandom_range(0, 15));
          addr[g]  = rand_addr();
          wdata[g] = $urandom;
        end
        mgnt[g]   = $urandom_range(0, 3) != 0;
        mrdata[g] = $urandom;
      end
      rst_n = (c != 300);
      step();
    end
    rst_n = 1'b1;
    for (int g = 0; g < N; g++) req[g] = 1'b0;
    repeat (8) step();

    // ---------------- final report ----------------
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

endmodule
